detectfaces_mul_pipe_hs: RTL and testbench

Parametrised, pipelined multiplier for the detectFaces datapath, replacing the fixed-width combinational signed×unsigned multipliers. Adds configurable pipeline depth, a selectable signed/unsigned mode for operand 1, and a valid/ready handshake so that the multiply can sit between stalling stages, such as the integral-image and window-sum pipelines. Defaults reproduce the 13s × 16ns → 29 product, registered over 3 stages.

---
 rtl/detectfaces_mul_pipe_hs.sv | 203 ++++++++++++++++++++
 tb/tb_detectfaces_mul_pipe_hs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/detectfaces_mul_pipe_hs.sv
// ---------------------------------------------------------------------------
// detectfaces_mul_pipe_hs
//
// Pipelined signed x (un)signed multiplier with a valid/ready handshake, for
// use between stalling stages of the detectFaces datapath (integral image,
// window sums). Defaults give a 13s x 16u -> 29-bit product over 3 stages.
//
// Parameters
//   din0_WIDTH   width of operand 0 (always two's complement)
//   din1_WIDTH   width of operand 1
//   dout_WIDTH   width of the result
//   NUM_STAGE    pipeline depth in cycles, 1..4
//   DIN1_SIGNED  0: operand 1 unsigned (zero-extended), 1: two's complement
//
// Ports
//   ap_clk     in   single clock, rising edge
//   ap_rst     in   synchronous active-high reset; flushes the pipe
//   in_valid   in   operands valid
//   in_ready   out  operands accepted this cycle (= advance)
//   din0       in   operand 0
//   din1       in   operand 1
//   out_valid  out  dout holds a result
//   out_ready  in   downstream takes the result
//   dout       out  product (sign-extended, truncated or clamped)
//   sat        out  only with DETECTFACES_MUL_SAT_EN: result was clamped
//
// Build option
//   DETECTFACES_MUL_SAT_EN  when defined and dout_WIDTH is narrower than the
//                           full product, clamp to the signed dout_WIDTH
//                           range and expose the 'sat' flag; otherwise the
//                           product is truncated to its low bits.
// ---------------------------------------------------------------------------
module detectfaces_mul_pipe_hs #(
    parameter int din0_WIDTH  = 13,
    parameter int din1_WIDTH  = 16,
    parameter int dout_WIDTH  = 29,
    parameter int NUM_STAGE   = 3,
    parameter int DIN1_SIGNED = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout
`ifdef DETECTFACES_MUL_SAT_EN
    ,
    output logic                  sat
`endif
);

    // The exact product of a signed n0-bit and an (un)signed n1-bit operand
    // always fits in n0+n1 signed bits, so arithmetic at FULL_W is exact.
    localparam int FULL_W = din0_WIDTH + din1_WIDTH;

    // First stage holding a result: with one stage the multiply sits in front
    // of the only register; otherwise stage 1 captures operands and the
    // product is registered in stage 2.
    localparam int RS = (NUM_STAGE == 1) ? 1 : 2;

    // -----------------------------------------------------------------------
    // Handshake and valid pipe
    // -----------------------------------------------------------------------
    logic [NUM_STAGE:1] vld;
    logic               advance;

    assign advance   = out_ready | ~vld[NUM_STAGE];
    assign in_ready  = advance;
    assign out_valid = vld[NUM_STAGE];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld <= '0;
        end else if (advance) begin
            vld[1] <= in_valid;
            for (int unsigned i = 2; i <= NUM_STAGE; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Operand source for the multiplier
    // -----------------------------------------------------------------------
    logic [din0_WIDTH-1:0] mul_a;
    logic [din1_WIDTH-1:0] mul_b;

    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign mul_a = din0;
            assign mul_b = din1;
        end else begin : g_capture
            logic [din0_WIDTH-1:0] a_q;
            logic [din1_WIDTH-1:0] b_q;

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= din0;
                    b_q <= din1;
                end
            end

            assign mul_a = a_q;
            assign mul_b = b_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Multiply at full width
    // -----------------------------------------------------------------------
    logic signed [FULL_W-1:0] ax;
    logic signed [FULL_W-1:0] bx;
    logic signed [FULL_W-1:0] prod;

    assign ax = FULL_W'(signed'(mul_a));

    generate
        if (DIN1_SIGNED != 0) begin : g_b_signed
            assign bx = FULL_W'(signed'(mul_b));
        end else begin : g_b_unsigned
            assign bx = FULL_W'(mul_b);
        end
    endgenerate

    assign prod = ax * bx;

    // -----------------------------------------------------------------------
    // Output sizing
    // -----------------------------------------------------------------------
    logic [dout_WIDTH-1:0] res_d;
`ifdef DETECTFACES_MUL_SAT_EN
    logic                  sat_d;
`endif

    generate
        if (dout_WIDTH >= FULL_W) begin : g_widen
            assign res_d = dout_WIDTH'(prod);
`ifdef DETECTFACES_MUL_SAT_EN
            assign sat_d = 1'b0;
`endif
        end else begin : g_narrow
`ifdef DETECTFACES_MUL_SAT_EN
            // The value fits iff every bit from the new sign position upward
            // equals the sign; otherwise clamp toward the product's sign.
            logic [FULL_W-dout_WIDTH:0] hi;
            logic                       ovf;

            assign hi    = prod[FULL_W-1:dout_WIDTH-1];
            assign ovf   = ~((&hi) | ~(|hi));
            assign res_d = !ovf            ? prod[dout_WIDTH-1:0] :
                           prod[FULL_W-1]  ? {1'b1, {(dout_WIDTH-1){1'b0}}} :
                                             {1'b0, {(dout_WIDTH-1){1'b1}}};
            assign sat_d = ovf;
`else
            assign res_d = prod[dout_WIDTH-1:0];
`endif
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Result pipe: stages RS..NUM_STAGE carry the sized product
    // -----------------------------------------------------------------------
    logic [dout_WIDTH-1:0] res_q [RS:NUM_STAGE];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int unsigned i = RS; i <= NUM_STAGE; i++) begin
                res_q[i] <= '0;
            end
        end else if (advance) begin
            res_q[RS] <= res_d;
            for (int unsigned i = RS + 1; i <= NUM_STAGE; i++) begin
                res_q[i] <= res_q[i-1];
            end
        end
    end

    assign dout = res_q[NUM_STAGE];

`ifdef DETECTFACES_MUL_SAT_EN
    logic [NUM_STAGE:RS] sat_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sat_q <= '0;
        end else if (advance) begin
            sat_q[RS] <= sat_d;
            for (int unsigned i = RS + 1; i <= NUM_STAGE; i++) begin
                sat_q[i] <= sat_q[i-1];
            end
        end
    end

    assign sat = sat_q[NUM_STAGE];
`endif

endmodule

// File: tb/tb_detectfaces_mul_pipe_hs.sv
// ---------------------------------------------------------------------------
// tb_detectfaces_mul_pipe_hs
//
// Three instances share clock, reset and stimulus:
//   u_def : default parameters (13s x 16u -> 29, 3 stages)
//   u_sgn : DIN1_SIGNED=1
//   u_nar : dout_WIDTH=16 (truncation, or clamping with DETECTFACES_MUL_SAT_EN)
// Directed vectors with hand-computed results, plus a scoreboard on u_def for
// streaming and backpressure sequences.
// ---------------------------------------------------------------------------
module tb_detectfaces_mul_pipe_hs;

`ifdef DETECTFACES_MUL_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [12:0] din0;
    logic [15:0] din1;

    logic        rdy_a, ov_a;
    logic [28:0] dout_a;
    logic        rdy_s, ov_s;
    logic [28:0] dout_s;
    logic        rdy_n, ov_n;
    logic [15:0] dout_n;
`ifdef DETECTFACES_MUL_SAT_EN
    logic        sat_a, sat_s, sat_n;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          sb_en   = 1'b0;
    int          n_pop   = 0;
    logic [28:0] sbq[$];

    always #5 clk = ~clk;

    detectfaces_mul_pipe_hs u_def (
        .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .din0(din0), .din1(din1), .out_valid(ov_a), .out_ready(out_ready),
        .dout(dout_a)
`ifdef DETECTFACES_MUL_SAT_EN
        , .sat(sat_a)
`endif
    );

    detectfaces_mul_pipe_hs #(.DIN1_SIGNED(1)) u_sgn (
        .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
        .din0(din0), .din1(din1), .out_valid(ov_s), .out_ready(out_ready),
        .dout(dout_s)
`ifdef DETECTFACES_MUL_SAT_EN
        , .sat(sat_s)
`endif
    );

    detectfaces_mul_pipe_hs #(.dout_WIDTH(16)) u_nar (
        .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(rdy_n),
        .din0(din0), .din1(din1), .out_valid(ov_n), .out_ready(out_ready),
        .dout(dout_n)
`ifdef DETECTFACES_MUL_SAT_EN
        , .sat(sat_n)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference product for the default instance: signed din0 x unsigned din1.
    function automatic logic [28:0] model(input logic [12:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'({1'b0, b});
        return p[28:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current cycle and, if enabled, run the scoreboard
    // on the transfers that the coming edge will perform.
    task automatic drive(input logic iv, input logic [12:0] a, input logic [15:0] b,
                         input logic ordy);
        in_valid  = iv;
        din0      = a;
        din1      = b;
        out_ready = ordy;
        #1;
        if (sb_en) begin
            if (ov_a && out_ready) begin
                check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    check("sb_dout", 32'(dout_a), 32'(sbq.pop_front()));
                    n_pop++;
                end
            end
            if (in_valid && rdy_a) sbq.push_back(model(a, b));
        end
    endtask

    task automatic single(input logic [12:0] a, input logic [15:0] b,
                          input logic [28:0] ea, input logic [28:0] es,
                          input logic [15:0] en_trunc, input logic [15:0] en_sat,
                          input logic esat);
        drive(1'b1, a, b, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1);
        check("lat_c1", 32'(ov_a), 32'd0);
        tick();
        check("lat_c2", 32'(ov_a), 32'd0);
        tick();
        check("lat_c3_def", 32'(ov_a), 32'd1);
        check("lat_c3_sgn", 32'(ov_s), 32'd1);
        check("lat_c3_nar", 32'(ov_n), 32'd1);
        check("dout_def", 32'(dout_a), 32'(ea));
        check("dout_sgn", 32'(dout_s), 32'(es));
        check("dout_nar", 32'(dout_n), 32'(SAT_BUILD ? en_sat : en_trunc));
`ifdef DETECTFACES_MUL_SAT_EN
        check("sat_def", 32'(sat_a), 32'd0);
        check("sat_sgn", 32'(sat_s), 32'd0);
        check("sat_nar", 32'(sat_n), 32'(esat));
`else
        if (esat === 1'bx) $display("unreachable");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with inputs presented that must be discarded
        rst = 1'b1;
        drive(1'b1, 13'd5, 16'd5, 1'b1);
        tick();
        check("rst_ov", 32'(ov_a), 32'd0);
        check("rst_dout", 32'(dout_a), 32'd0);
        check("rst_rdy", 32'(rdy_a), 32'd1);
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("rst_discard", 32'(ov_a), 32'd0);
            tick();
        end

        // Directed single multiplies on all three instances
        single(13'h1000, 16'hFFFF, 29'h10001000, 29'h00001000, 16'h1000, 16'h8000, 1'b1);
        single(13'd5,    16'hFFFF, 29'h0004FFFB, 29'h1FFFFFFB, 16'hFFFB, 16'h7FFF, 1'b1);
        single(13'd4095, 16'hFFFF, 29'h0FFEF001, 29'h1FFFF001, 16'hF001, 16'h7FFF, 1'b1);
        single(13'h1FFD, 16'd7,    29'h1FFFFFEB, 29'h1FFFFFEB, 16'hFFEB, 16'hFFEB, 1'b0);
        single(13'h1FFF, 16'h8000, 29'h1FFF8000, 29'h00008000, 16'h8000, 16'h8000, 1'b0);
        single(13'h0FFF, 16'd8,    29'h00007FF8, 29'h00007FF8, 16'h7FF8, 16'h7FF8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1);
            tick();
        end

        // Streaming: 8 back-to-back inputs, results in cycles 3..10, no gaps
        sb_en = 1'b1;
        n_pop = 0;
        for (int j = 0; j < 13; j++) begin
            if (j < 8) drive(1'b1, 13'(j - 4), 16'(1000 * j), 1'b1);
            else       drive(1'b0, '0, '0, 1'b1);
            check("strm_ov", 32'(ov_a), 32'(j >= 3 && j <= 10));
            tick();
        end
        check("strm_count", 32'(n_pop), 32'd8);
        check("strm_empty", 32'(sbq.size()), 32'd0);

        // Backpressure: fill, stall 5 cycles, release
        n_pop = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 13'(k * 37 - 100), 16'(k * 1111 + 5), 1'b1);
            tick();
        end
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, 13'(3 * 37 - 100), 16'(3 * 1111 + 5), 1'b0);
            check("bp_rdy", 32'(rdy_a), 32'd0);
            check("bp_ov", 32'(ov_a), 32'd1);
            check("bp_hold", 32'(dout_a), 32'(model(13'(-100), 16'd5)));
            tick();
        end
        for (int k = 3; k < 6; k++) begin
            drive(1'b1, 13'(k * 37 - 100), 16'(k * 1111 + 5), 1'b1);
            tick();
        end
        for (int d = 0; d < 5; d++) begin
            drive(1'b0, '0, '0, 1'b1);
            tick();
        end
        check("bp_count", 32'(n_pop), 32'd6);
        check("bp_empty", 32'(sbq.size()), 32'd0);
        sb_en = 1'b0;

        // Reset with three items in flight
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 13'(k + 11), 16'(k + 200), 1'b1);
            tick();
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        check("mid_pre_ov", 32'(ov_a), 32'd1);
        tick();
        rst = 1'b0;
        check("mid_rst_ov", 32'(ov_a), 32'd0);
        check("mid_rst_dout", 32'(dout_a), 32'd0);
        check("mid_rst_dout_nar", 32'(dout_n), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b1);
            check("mid_no_ghost", 32'(ov_a), 32'd0);
            tick();
        end
        drive(1'b1, 13'd100, 16'd300, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1);
        check("fresh_c1", 32'(ov_a), 32'd0);
        tick();
        check("fresh_c2", 32'(ov_a), 32'd0);
        tick();
        check("fresh_c3", 32'(ov_a), 32'd1);
        check("fresh_dout", 32'(dout_a), 32'd30000);
        tick();
        check("fresh_drain", 32'(ov_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
